vga_clk_en_gen: RTL and testbench

- Multi-channel programmable divider for the VGA subsystem. Generates per-channel clock-enable strobes and divided square waves from the single system clock.
- Supersedes the single-channel divider:
  - Channel count and counter width are parametrised.
  - Each channel selects pulse or 50% toggle mode.
  - Divisor changes are glitch-free, held in a shadow register until a safe boundary.
  - A global SYNC realigns all channels.
- Downstream logic uses CE_OUT as an enable on CLK. CLK_OUT is a registered data signal only and is never used as a clock.

---
 rtl/vga_clk_en_gen.sv | 156 +++++++++++++++
 tb/tb_vga_clk_en_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_clk_en_gen.sv
// Multi-channel programmable clock-enable generator for the VGA subsystem.
// Each channel produces a one-cycle CE strobe and a pulse or 50% toggle waveform.

module vga_clk_en_ch #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] div_new_i,
   input  logic             mode_new_i,
   input  logic [WIDTH-1:0] div_stg_i,
   input  logic             mode_stg_i,
   output logic             ce_o,
   output logic             co_o,
   output logic             pend_d_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, d_eff;
   logic             mode_q, mode_d, ce_q, ce_d, co_q, co_d, pend_q, pend_d;
   logic             term, apply;

   assign d_eff = (div_q == '0) ? ONE : div_q;
   assign term  = (cnt_q == d_eff - ONE);

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      mode_d = mode_q;
      ce_d   = ce_q;
      co_d   = co_q;
      pend_d = pend_q;
      apply  = 1'b0;
      if (sync_i) begin
         cnt_d  = '0;
         ce_d   = 1'b0;
         co_d   = 1'b0;
         pend_d = 1'b0;
         // A LOAD coinciding with SYNC bypasses the staging registers.
         if (load_i) begin
            div_d  = div_new_i;
            mode_d = mode_new_i;
         end else if (pend_q) begin
            div_d  = div_stg_i;
            mode_d = mode_stg_i;
         end
      end else begin
         if (!en_i) begin
            cnt_d = '0;
            ce_d  = 1'b0;
            co_d  = 1'b0;
            apply = pend_q;
         end else if (term) begin
            cnt_d = '0;
            ce_d  = 1'b1;
            co_d  = mode_q ? ~co_q : 1'b1;
            apply = pend_q;
            if (pend_q && (mode_stg_i != mode_q)) co_d = 1'b0;
         end else begin
            cnt_d = cnt_q + ONE;
            ce_d  = 1'b0;
            if (!mode_q) co_d = 1'b0;
         end
         if (apply) begin
            div_d  = div_stg_i;
            mode_d = mode_stg_i;
            pend_d = 1'b0;
         end
         if (load_i) pend_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q  <= '0;
         div_q  <= ONE;
         mode_q <= 1'b0;
         ce_q   <= 1'b0;
         co_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         mode_q <= mode_d;
         ce_q   <= ce_d;
         co_q   <= co_d;
         pend_q <= pend_d;
      end
   end

   assign ce_o     = ce_q;
   assign co_o     = co_q;
   assign pend_d_o = pend_d;

endmodule

module vga_clk_en_gen #(
   parameter int CH    = 2,
   parameter int WIDTH = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CH-1:0]       EN,
   input  logic [CH*WIDTH-1:0] DIV,
   input  logic [CH-1:0]       MODE,
   input  logic                LOAD,
   input  logic                SYNC,
   output logic [CH-1:0]       CE_OUT,
   output logic [CH-1:0]       CLK_OUT,
   output logic                BUSY
);

   logic [CH-1:0][WIDTH-1:0] div_in, div_stg_q;
   logic [CH-1:0]            mode_stg_q, pend_d;
   logic                     busy_q;

   assign div_in = DIV;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div_stg_q  <= '0;
         mode_stg_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         if (LOAD) begin
            div_stg_q  <= div_in;
            mode_stg_q <= MODE;
         end
         busy_q <= |pend_d;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      vga_clk_en_ch #(.WIDTH(WIDTH)) u_ch (
         .CLK        (CLK),
         .RST        (RST),
         .en_i       (EN[g]),
         .sync_i     (SYNC),
         .load_i     (LOAD),
         .div_new_i  (div_in[g]),
         .mode_new_i (MODE[g]),
         .div_stg_i  (div_stg_q[g]),
         .mode_stg_i (mode_stg_q[g]),
         .ce_o       (CE_OUT[g]),
         .co_o       (CLK_OUT[g]),
         .pend_d_o   (pend_d[g])
      );
   end

   assign BUSY = busy_q;

endmodule

// File: tb/tb_vga_clk_en_gen.sv
// Bench for vga_clk_en_gen: elapsed-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_vga_clk_en_gen;
   localparam int CH = 2, WIDTH = 16;

   logic CLK = 1'b0, RST = 1'b0, LOAD = 1'b0, SYNC = 1'b0;
   logic [CH-1:0] EN = '0, MODE = '0;
   logic [CH*WIDTH-1:0] DIV = '0;
   logic [CH-1:0] CE_OUT, CLK_OUT;
   logic BUSY;

   int checks = 0, failures = 0;
   bit chk_on = 1'b0;

   always #5 CLK = ~CLK;

   vga_clk_en_gen #(.CH(CH), .WIDTH(WIDTH)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .MODE(MODE),
      .LOAD(LOAD), .SYNC(SYNC), .CE_OUT(CE_OUT), .CLK_OUT(CLK_OUT), .BUSY(BUSY)
   );

   // Reference model: each channel runs "segments" starting at edge m_start;
   // strobes fall where the elapsed edge count completes a period of d.
   int m_d[CH], m_sdiv[CH], m_start[CH];
   int t = 0;
   logic [CH-1:0] m_mode = '0, m_smode = '0, m_pend = '0, m_ce = '0, m_co = '0, m_lvl0 = '0;
   logic m_busy = 1'b0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int c = 0; c < CH; c++) begin
            m_d[c] = 1; m_sdiv[c] = 0; m_start[c] = t + 1;
         end
         m_mode = '0; m_smode = '0; m_pend = '0; m_ce = '0; m_co = '0; m_lvl0 = '0;
         m_busy = 1'b0;
      end else begin
         t++;
         for (int c = 0; c < CH; c++) begin
            int dd, pos;
            if (SYNC || !EN[c]) begin
               m_ce[c] = 1'b0; m_co[c] = 1'b0;
               if (SYNC && LOAD) begin
                  m_d[c] = int'(DIV[c*WIDTH +: WIDTH]); m_mode[c] = MODE[c];
               end else if (m_pend[c]) begin
                  m_d[c] = m_sdiv[c]; m_mode[c] = m_smode[c];
               end
               m_pend[c] = 1'b0; m_start[c] = t + 1; m_lvl0[c] = 1'b0;
            end else begin
               dd = (m_d[c] == 0) ? 1 : m_d[c];
               pos = t - m_start[c];
               m_ce[c] = (pos % dd == dd - 1);
               m_co[c] = m_mode[c] ? ((((pos + 1) / dd) + int'(m_lvl0[c])) % 2 == 1) : m_ce[c];
               if (m_ce[c] && m_pend[c]) begin
                  if (m_smode[c] != m_mode[c]) m_co[c] = 1'b0;
                  m_d[c] = m_sdiv[c]; m_mode[c] = m_smode[c];
                  m_pend[c] = 1'b0; m_start[c] = t + 1; m_lvl0[c] = m_co[c];
               end
            end
            if (LOAD && !SYNC) m_pend[c] = 1'b1;
         end
         if (LOAD) begin
            for (int c = 0; c < CH; c++) m_sdiv[c] = int'(DIV[c*WIDTH +: WIDTH]);
            m_smode = MODE;
         end
         m_busy = |m_pend;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Literal expectation applied to both the DUT and the model.
   task automatic pin(input string nm, input logic dv, input logic mv, input logic exp);
      chk({nm, "_dut"}, 32'(dv), 32'(exp));
      chk({nm, "_mdl"}, 32'(mv), 32'(exp));
   endtask

   always @(negedge CLK) begin
      if (chk_on) begin
         chk("cmp_ce", 32'(CE_OUT), 32'(m_ce));
         chk("cmp_co", 32'(CLK_OUT), 32'(m_co));
         chk("cmp_busy", 32'(BUSY), 32'(m_busy));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic cmd(input logic ld, input logic sy, input logic [WIDTH-1:0] d0,
                      input logic [WIDTH-1:0] d1, input logic [1:0] md);
      DIV = {d1, d0}; MODE = md; LOAD = ld; SYNC = sy;
      step(1);
      LOAD = 1'b0; SYNC = 1'b0;
   endtask

   initial begin
      EN = '1;
      step(2);
      chk("rst_ce", 32'(CE_OUT), 0);
      chk("rst_co", 32'(CLK_OUT), 0);
      chk("rst_busy", 32'(BUSY), 0);
      RST = 1'b1;
      chk_on = 1'b1;

      // ch0 pulse d=4, ch1 toggle d=3, aligned by SYNC
      cmd(1, 0, 4, 3, 2'b10);
      pin("t1_busy", BUSY, m_busy, 1'b1);
      cmd(0, 1, 4, 3, 2'b10);
      pin("t1_busy_clr", BUSY, m_busy, 1'b0);
      for (int k = 0; k < 12; k++) begin
         step(1);
         pin("t1_ce0", CE_OUT[0], m_ce[0], (k % 4 == 3));
         pin("t1_co1", CLK_OUT[1], m_co[1], (((k + 1) / 3) % 2 == 1));
      end

      // toggle with d=1 and d=0 both give CLK/2
      for (int v = 1; v >= 0; v--) begin
         cmd(1, 1, 4, WIDTH'(v), 2'b10);
         for (int k = 0; k < 6; k++) begin
            step(1);
            pin("t2_co1", CLK_OUT[1], m_co[1], ((k + 1) % 2 == 1));
         end
      end

      // d=10 running, LOAD d=2 at count 4
      cmd(1, 1, 10, 1, 2'b00);
      step(4);
      cmd(1, 0, 2, 1, 2'b00);
      pin("t3_busy_set", BUSY, m_busy, 1'b1);
      for (int k = 5; k < 16; k++) begin
         step(1);
         pin("t3_busy", BUSY, m_busy, (k < 9));
         pin("t3_ce0", CE_OUT[0], m_ce[0], (k == 9 || k == 11 || k == 13 || k == 15));
      end

      // second LOAD overrides the first while still pending
      cmd(1, 1, 10, 1, 2'b00);
      cmd(1, 0, 7, 1, 2'b00);
      cmd(1, 0, 5, 1, 2'b00);
      for (int k = 2; k < 20; k++) begin
         step(1);
         pin("t4_ce0", CE_OUT[0], m_ce[0], (k == 9 || k == 14 || k == 19));
         pin("t4_busy", BUSY, m_busy, (k < 9));
      end

      // LOAD+SYNC applies immediately; later SYNC realigns
      cmd(1, 1, 3, 5, 2'b00);
      for (int k = 0; k < 15; k++) begin
         step(1);
         pin("t5_ce0", CE_OUT[0], m_ce[0], (k % 3 == 2));
         pin("t5_ce1", CE_OUT[1], m_ce[1], (k % 5 == 4));
      end
      step(2);
      cmd(0, 1, 0, 0, 2'b00);
      chk("t5_sync_ce", 32'(CE_OUT), 0);
      chk("t5_sync_co", 32'(CLK_OUT), 0);
      for (int k = 0; k < 5; k++) begin
         step(1);
         pin("t5_resync_ce0", CE_OUT[0], m_ce[0], (k % 3 == 2));
      end

      // EN[0] low, then asynchronous reset between edges
      EN = 2'b10;
      step(3);
      pin("t6_en_ce0", CE_OUT[0], m_ce[0], 1'b0);
      pin("t6_en_co0", CLK_OUT[0], m_co[0], 1'b0);
      cmd(1, 0, 9, 9, 2'b00);
      pin("t6_busy", BUSY, m_busy, 1'b1);
      @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("t6_arst_ce", 32'(CE_OUT), 0);
      chk("t6_arst_co", 32'(CLK_OUT), 0);
      chk("t6_arst_busy", 32'(BUSY), 0);
      @(negedge CLK);
      RST = 1'b1; EN = 2'b11;
      for (int k = 0; k < 2; k++) begin
         step(1);
         chk("t6_rel_ce", 32'(CE_OUT), 32'h3);
         chk("t6_rel_co", 32'(CLK_OUT), 32'h3);
      end

      // randomized traffic, model compared every cycle
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            EN[c] = ($urandom_range(7, 0) != 0);
            DIV[c*WIDTH +: WIDTH] = ($urandom_range(9, 0) == 0) ? WIDTH'($urandom_range(40, 0))
                                                                : WIDTH'($urandom_range(6, 0));
            MODE[c] = $urandom_range(1, 0) == 1;
         end
         LOAD = ($urandom_range(15, 0) == 0);
         SYNC = ($urandom_range(49, 0) == 0);
         if ($urandom_range(399, 0) == 0) begin
            @(posedge CLK);
            #3 RST = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
         end else begin
            step(1);
         end
      end
      LOAD = 1'b0; SYNC = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
